// File: rtl/alu_seq.sv
// alu_seq: small sequential ALU with a valid/ready handshake on both sides.
// Single-cycle operations (AND, XOR, add, shift, rotate, bypass) register
// their result on the accept edge. Unsigned multiply runs shift-add, one
// partial product per cycle. Every result is held until the consumer takes it.
module alu_seq #(
    parameter int WIDTH          = 4,
    parameter bit INPUT_PRIORITY = 1'b1,
    parameter bit FULL_ADDER     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 cin,
    input  logic                 red_op_A,
    input  logic                 red_op_B,
    input  logic                 bypass_A,
    input  logic                 bypass_B,
    input  logic                 direction,
    input  logic [2:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   Out,
    output logic                 Odd_parity,
    output logic                 Invalid
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [2*WIDTH-1:0]     r_out;
    logic                   r_parity;
    logic                   r_invalid;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [CW-1:0]          r_cnt;

    logic                   w_accept;
    logic                   w_invalid;
    logic                   w_bypass;
    logic                   w_is_mul;
    logic                   w_mul_last;
    logic [WIDTH-1:0]       w_byp_sel;
    logic [WIDTH-1:0]       w_red_sel;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_result;
    logic [2*WIDTH-1:0]     w_acc_next;

    // Ready only in IDLE and never while reset is held.
    assign in_ready   = (r_state == IDLE) && rst_n;
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = (r_state == HOLD);
    assign Out        = r_out;
    assign Odd_parity = r_parity;
    assign Invalid    = r_invalid;
    assign w_mul_last = (r_cnt == CW'(WIDTH - 1));

    // Decode the presented operation and form the single-cycle result.
    always_comb begin
        w_invalid = (opcode[2:1] == 2'b11) ||
                    ((red_op_A || red_op_B) && (opcode[2:1] != 2'b00));
        w_bypass  = bypass_A || bypass_B;
        w_byp_sel = (bypass_A && bypass_B) ? (INPUT_PRIORITY ? A : B)
                                           : (bypass_A ? A : B);
        w_red_sel = (red_op_A && red_op_B) ? (INPUT_PRIORITY ? A : B)
                                           : (red_op_A ? A : B);
        w_is_mul  = !w_invalid && !w_bypass && (opcode == 3'b011);
        w_sum     = {1'b0, A} + {1'b0, B} +
                    (FULL_ADDER ? {{WIDTH{1'b0}}, cin} : {(WIDTH+1){1'b0}});
        w_result  = '0;
        if (w_invalid) begin
            w_result = '0;
        end else if (w_bypass) begin
            w_result = {{WIDTH{1'b0}}, w_byp_sel};
        end else begin
            case (opcode)
                3'b000: begin
                    if (red_op_A || red_op_B)
                        w_result = {{(2*WIDTH-1){1'b0}}, &w_red_sel};
                    else
                        w_result = {{WIDTH{1'b0}}, A & B};
                end
                3'b001: begin
                    if (red_op_A || red_op_B)
                        w_result = {{(2*WIDTH-1){1'b0}}, ^w_red_sel};
                    else
                        w_result = {{WIDTH{1'b0}}, A ^ B};
                end
                3'b010: w_result = {{(WIDTH-1){1'b0}}, w_sum};
                3'b100: begin
                    if (direction)
                        w_result = {{WIDTH{1'b0}}, A[WIDTH-2:0], cin};
                    else
                        w_result = {{WIDTH{1'b0}}, cin, A[WIDTH-1:1]};
                end
                3'b101: begin
                    if (direction)
                        w_result = {{WIDTH{1'b0}}, A[WIDTH-2:0], A[WIDTH-1]};
                    else
                        w_result = {{WIDTH{1'b0}}, A[0], A[WIDTH-1:1]};
                end
                default: w_result = '0;
            endcase
        end
    end

    // Accumulator plus the current partial product (multiplier LSB selects it).
    always_comb begin
        w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {(2*WIDTH){1'b0}});
    end

    // Next-state logic: multiply detours through MUL, everything else goes to HOLD.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = w_is_mul ? MUL : HOLD;
            MUL:     if (w_mul_last) w_state_next = HOLD;
            HOLD:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Datapath: capture on accept, step the multiplier, load the result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out     <= '0;
            r_parity  <= 1'b0;
            r_invalid <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_mcand  <= {{WIDTH{1'b0}}, A};
                            r_mplier <= B;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                        end else begin
                            r_out     <= w_result;
                            r_parity  <= ^w_result;
                            r_invalid <= w_invalid;
                        end
                    end
                end
                MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_mul_last) begin
                        r_out     <= w_acc_next;
                        r_parity  <= ^w_acc_next;
                        r_invalid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random operations on alu_seq, each compared
// against an arithmetic reference model of the ALU's rules.
module tb_alu_seq;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic           cin = 1'b0;
    logic           red_op_A = 1'b0;
    logic           red_op_B = 1'b0;
    logic           bypass_A = 1'b0;
    logic           bypass_B = 1'b0;
    logic           direction = 1'b0;
    logic [2:0]     opcode = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] Out;
    logic           Odd_parity;
    logic           Invalid;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(.WIDTH(W), .INPUT_PRIORITY(1'b1), .FULL_ADDER(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .cin(cin), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .direction(direction),
        .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .Out(Out), .Odd_parity(Odd_parity), .Invalid(Invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation rules.
    function automatic void model(input int a, input int b, input int ci,
                                  input bit ra, input bit rb, input bit ba, input bit bb,
                                  input bit dir, input int op,
                                  output int o, output bit inv, output int lat);
        int sel;
        lat = 1;
        o   = 0;
        inv = (op >= 6) || ((ra || rb) && op > 1);
        if (inv) begin
            o = 0;
        end else if (ba || bb) begin
            o = (ba && bb) ? a : (ba ? a : b);
        end else begin
            sel = (ra && rb) ? a : (ra ? a : b);
            case (op)
                0: o = (ra || rb) ? ((sel == 15) ? 1 : 0) : (a & b);
                1: o = (ra || rb) ? ($countones(sel) % 2) : (a ^ b);
                2: o = a + b + ci;
                3: begin o = a * b; lat = W + 1; end
                4: o = dir ? (((a * 2) + ci) % 16) : ((ci * 8) + (a / 2));
                5: o = dir ? (((a * 2) % 16) + (a / 8)) : (((a % 2) * 8) + (a / 2));
                default: o = 0;
            endcase
        end
    endfunction

    // One full transaction: present, wait for result, check, optionally stall, release.
    task automatic run_op(input string name, input int a, input int b, input int ci,
                          input bit ra, input bit rb, input bit ba, input bit bb,
                          input bit dir, input int op, input int stall);
        int  exp_o;
        bit  exp_inv;
        int  exp_lat;
        int  lat;
        logic [2*W-1:0] held;
        model(a, b, ci, ra, rb, ba, bb, dir, op, exp_o, exp_inv, exp_lat);
        @(negedge clk);
        check({name, ".in_ready"}, 32'(in_ready), 32'd1);
        A = W'(a); B = W'(b); cin = ci[0]; red_op_A = ra; red_op_B = rb;
        bypass_A = ba; bypass_B = bb; direction = dir; opcode = 3'(op);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        // Scramble inputs after the accept edge; they must have no effect.
        in_valid = 1'b0; A = W'($urandom); B = W'($urandom); opcode = 3'($urandom);
        cin = 1'($urandom); direction = 1'($urandom);
        red_op_A = 1'b0; red_op_B = 1'b0; bypass_A = 1'b0; bypass_B = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check({name, ".latency"}, 32'(lat), 32'(exp_lat));
        check({name, ".Out"}, 32'(Out), 32'(exp_o));
        check({name, ".Odd_parity"}, 32'(Odd_parity), 32'($countones(exp_o) % 2));
        check({name, ".Invalid"}, 32'(Invalid), 32'(exp_inv));
        held = Out;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; A = W'($urandom); opcode = 3'($urandom);
            @(negedge clk);
            check({name, ".stall_Out"}, 32'(Out), 32'(held));
            check({name, ".stall_valid"}, 32'(out_valid), 32'd1);
            check({name, ".stall_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check({name, ".release_valid"}, 32'(out_valid), 32'd0);
        check({name, ".release_ready"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        $display("op %-10s A=%0h B=%0h opc=%0d -> Out=%0h par=%0b inv=%0b lat=%0d",
                 name, a, b, op, held, Odd_parity, Invalid, lat);
    endtask

    initial begin
        int a, b, op, lat;
        bit ra, rb, ba, bb;
        // Reset state.
        #2;
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.Out", 32'(Out), 32'd0);
        check("rst.Odd_parity", 32'(Odd_parity), 32'd0);
        check("rst.Invalid", 32'(Invalid), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_op("add",      15, 1,  1, 0, 0, 0, 0, 0, 2, 0);
        run_op("mul",      15, 15, 0, 0, 0, 0, 0, 0, 3, 0);
        run_op("backpres", 6,  3,  0, 0, 0, 0, 0, 0, 1, 3);
        run_op("ill110",   5,  9,  0, 0, 0, 0, 0, 0, 6, 0);
        run_op("redadd",   5,  9,  0, 1, 0, 0, 0, 0, 2, 0);
        run_op("byp111",   5,  9,  0, 0, 0, 1, 0, 0, 7, 0);
        run_op("bypboth",  10, 5,  0, 0, 0, 1, 1, 0, 3, 0);
        run_op("redandA",  15, 0,  0, 1, 1, 0, 0, 0, 0, 0);
        run_op("redxorB",  15, 7,  0, 0, 1, 0, 0, 0, 1, 0);
        run_op("shl",      9,  0,  1, 0, 0, 0, 0, 1, 4, 0);
        run_op("shr",      9,  0,  1, 0, 0, 0, 0, 0, 4, 0);
        run_op("rotl",     9,  0,  0, 0, 0, 0, 0, 1, 5, 0);

        // Reset during multiply: result discarded at once.
        @(negedge clk);
        A = 4'd13; B = 4'd11; opcode = 3'b011; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b0; #1;
        check("rstmul.out_valid", 32'(out_valid), 32'd0);
        check("rstmul.Out", 32'(Out), 32'd0);
        check("rstmul.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        check("rstmul.no_result", 32'(lat), 32'd0);
        $display("op rstmul     reset in MUL, stray valid cycles=%0d", lat);
        run_op("rotr",     9,  0,  0, 0, 0, 0, 0, 0, 5, 0);

        // Random operations; flags kept sparse so real opcodes dominate.
        for (int n = 0; n < 60; n++) begin
            a  = int'($urandom_range(0, 15));
            b  = int'($urandom_range(0, 15));
            op = int'($urandom_range(0, 7));
            ra = ($urandom_range(0, 5) == 0);
            rb = ($urandom_range(0, 5) == 0);
            ba = ($urandom_range(0, 7) == 0);
            bb = ($urandom_range(0, 7) == 0);
            run_op("rand", a, b, int'($urandom_range(0, 1)), ra, rb, ba, bb,
                   1'($urandom), op, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 WIDTH, 4, operand width in bits; legal values >= 2.
REQ-002 INPUT_PRIORITY, 1, selects the operand when both bypass or both reduction flags are set: 1 = A, 0 = B.
REQ-003 FULL_ADDER, 1, 1 = add includes cin; 0 = cin ignored by add.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  operation presented.
REQ-008 in_ready  out  1  block accepts an operation; a transfer occurs when in_valid and in_ready are both high at a clk edge.
REQ-009 A, B  in  WIDTH  operands.
REQ-010 cin  in  1  carry in for add; serial-in bit for shift.
REQ-011 red_op_A, red_op_B  in  1  reduction request on A or on B.
REQ-012 bypass_A, bypass_B  in  1  pass operand A or B through unmodified.
REQ-013 direction  in  1  1 = left, 0 = right, for shift and rotate.
REQ-014 opcode  in  3  operation select.
REQ-015 out_valid  out  1  result present.
REQ-016 out_ready  in  1  consumer takes the result.
REQ-017 Out  out  2*WIDTH  registered result, zero-extended.
REQ-018 Odd_parity  out  1  XOR reduction of Out.
REQ-019 Invalid  out  1  the registered operation was illegal.

Function
REQ-020 States: IDLE, MUL, HOLD. in_ready = (state==IDLE) and rst_n.
REQ-021 All operands and controls are sampled only on the accept edge; changes on the inputs outside the accept edge have no effect.
REQ-022 Invalid = 1 when opcode is 110 or 111, or when either red_op flag is set with an opcode other than 000/001. Invalid takes precedence over bypass. The registered result is then Out=0, Odd_parity=0, and the state goes IDLE->HOLD.
REQ-023 Bypass: if bypass_A or bypass_B is set and the operation is valid, Out = the selected operand (INPUT_PRIORITY breaks the tie). opcode is ignored and the state goes IDLE->HOLD.
REQ-024 Operation 000 is AND: Out = A&B. With a reduction flag set it is &A or &B; INPUT_PRIORITY breaks the tie.
REQ-025 Operation 001 is XOR: Out = A^B. With a reduction flag set it is ^A or ^B; INPUT_PRIORITY breaks the tie.
REQ-026 Operation 010 is add: Out = A+B+(FULL_ADDER?cin:0) as a WIDTH+1-bit sum. The carry is in Out[WIDTH].
REQ-027 Operation 011 is unsigned multiply: shift-add, one partial product per cycle.
  - IDLE->MUL on accept; a cycle counter starts at 0.
  - After WIDTH cycles in MUL, Out = A*B (full 2*WIDTH bits) and the state goes to HOLD.
REQ-028 Operation 100 is shift by 1:
  - left: {A[WIDTH-2:0], cin}
  - right: {cin, A[WIDTH-1:1]}
REQ-029 Operation 101 is rotate by 1:
  - left: {A[WIDTH-2:0], A[WIDTH-1]}
  - right: {A[0], A[WIDTH-1:1]}
REQ-030 Latency from accept edge to out_valid=1:
  - non-multiply operations: 1 cycle.
  - multiply: WIDTH+1 cycles.
REQ-031 In HOLD, out_valid=1 and Out, Odd_parity and Invalid hold stable until out_ready=1. On that edge the state goes HOLD->IDLE and out_valid goes to 0.
REQ-032 in_valid is ignored in MUL and HOLD. Throughput is one operation per 2 cycles, or per WIDTH+2 cycles for multiply, with out_ready held high.
REQ-033 out_valid is never asserted without an accepted operation. Each accepted operation produces exactly one result.

Reset
REQ-034 While rst_n=0: state=IDLE, in_ready=0, out_valid=0, Out=0, Odd_parity=0, Invalid=0, and the multiply counter and accumulator are 0.
REQ-035 Reset asserted in MUL or HOLD discards the operation immediately. No result is produced for it.
REQ-036 The first accept is possible on the first rising edge with rst_n=1.

Verification (WIDTH=4, defaults)
REQ-037 Add: A=1111, B=0001, cin=1, opcode=010 -> one cycle later out_valid=1, Out=0x11, Odd_parity=0, Invalid=0.
REQ-038 Multiply: A=15, B=15, opcode=011 -> in_ready=0 for 5 cycles; then out_valid=1, Out=0xE1, Odd_parity=0.
REQ-039 Backpressure: result pending with out_ready=0 for 3 cycles -> Out stable, in_ready=0, extra in_valid pulses ignored; out_ready=1 -> IDLE on the next cycle.
REQ-040 Illegal operations, checked separately:
  - opcode=110 -> Invalid=1, Out=0.
  - red_op_A=1 with opcode=010 -> Invalid=1.
  - bypass_A=1 with opcode=111 -> Invalid=1.
REQ-041 Bypass with both flags: bypass_A=bypass_B=1, A=1010, B=0101, opcode=011 -> Out=0x0A after 1 cycle, no MUL state entered.
REQ-042 Reset during multiply: rst_n low at MUL cycle 2 -> out_valid=0 and Out=0 at once; after release, rotate right A=1001 -> Out=0x0C.
